// File: rtl/interleaver_ram_ctrl.sv
// -----------------------------------------------------------------------------
// interleaver_ram_ctrl
// Convolutional (Forney) interleaver controller driving an external
// single-port synchronous delay RAM. Each accepted byte is routed to one of
// B branches in rotation. Branch 0 is passed straight through. Branch k > 0
// is delayed by M*k branch-k transfers. The delay comes from a per-branch
// circular region of the RAM that starts at base(k) = M*k*(k-1)/2. Each of
// these bytes takes two RAM cycles: it reads the oldest entry and then
// overwrites that entry with the new byte.
// A side tracker counts 204-byte packets in groups of 8. It flags a wrong
// sync byte: 0xB8 is expected at the start of packet 0, and 0x47 at the
// start of every other packet.
//
// Ports
//   i_clk, i_reset : clock and synchronous active-high reset
//   i_enable       : gates upstream acceptance only; a byte in flight completes
//   i_di_rdy/o_di_acpt/i_di     : upstream handshake and byte
//   o_do_rdy/i_do_acpt/o_do_data: downstream handshake and interleaved byte
//   o_ram_addr/o_ram_we/o_ram_wdata/i_ram_rdata : delay-RAM port (registered)
//   o_sync_err     : one-cycle pulse after a bad sync byte
// -----------------------------------------------------------------------------
module interleaver_ram_ctrl #(
  parameter int WIDTH  = 8,
  parameter int M      = 17,
  parameter int B      = 12,
  parameter int ADDR_W = 11
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_di_rdy,
  output logic              o_di_acpt,
  input  logic [WIDTH-1:0]  i_di,
  output logic              o_do_rdy,
  input  logic              i_do_acpt,
  output logic [WIDTH-1:0]  o_do_data,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [WIDTH-1:0]  o_ram_wdata,
  input  logic [WIDTH-1:0]  i_ram_rdata,
  output logic              o_sync_err
);

  localparam int BR_W  = (B > 1) ? $clog2(B) : 1;
  // Largest pointer value is M*(B-1)-1, so clog2 of M*(B-1) is enough bits.
  localparam int PTR_W = (M * (B - 1) > 1) ? $clog2(M * (B - 1)) : 1;

  localparam logic [WIDTH-1:0] SYNC_P0 = WIDTH'(8'hB8);
  localparam logic [WIDTH-1:0] SYNC_PN = WIDTH'(8'h47);
  localparam logic [7:0]       BC_LAST = 8'd203;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t            r_state;
  logic [BR_W-1:0]   r_br;
  logic [BR_W-1:0]   r_cur_br;
  logic [WIDTH-1:0]  r_hold;
  logic [PTR_W-1:0]  r_ptr [B];
  logic              r_do_rdy;
  logic [WIDTH-1:0]  r_do_data;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_we;
  logic [WIDTH-1:0]  r_ram_wdata;
  logic [7:0]        r_bc;
  logic [2:0]        r_pc;
  logic              r_sync_err;

  logic              w_xfer;
  logic [WIDTH-1:0]  w_sync_exp;
  logic              w_sync_bad;

  // Start address of branch k's circular region: M*k*(k-1)/2.
  function automatic logic [ADDR_W-1:0] branch_base(input logic [BR_W-1:0] k);
    int kk;
    kk = int'(k);
    return ADDR_W'((M * kk * (kk - 1)) / 2);
  endfunction

  // Last valid pointer value of branch k (region length M*k).
  function automatic logic [PTR_W-1:0] ptr_last(input logic [BR_W-1:0] k);
    int kk;
    kk = int'(k);
    return PTR_W'(M * kk - 1);
  endfunction

  // Acceptance is forced low during reset so nothing transfers on a reset edge.
  assign o_di_acpt = (r_state == ST_IDLE) && i_enable && !i_reset;
  assign w_xfer    = i_di_rdy && o_di_acpt;

  // Expected sync byte for the current packet and the mismatch decision.
  always_comb begin
    w_sync_exp = SYNC_PN;
    w_sync_bad = 1'b0;
    if (r_pc == 3'd0) begin
      w_sync_exp = SYNC_P0;
    end else begin
      w_sync_exp = SYNC_PN;
    end
    if (w_xfer && (r_bc == 8'd0) && (i_di != w_sync_exp)) begin
      w_sync_bad = 1'b1;
    end else begin
      w_sync_bad = 1'b0;
    end
  end

  // Interleaver FSM: branch selection, RAM read/write sequencing, output hold.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_br        <= '0;
      r_cur_br    <= '0;
      r_hold      <= '0;
      r_do_rdy    <= 1'b0;
      r_do_data   <= '0;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      for (int i = 0; i < B; i++) begin
        r_ptr[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_br <= (r_br == BR_W'(B - 1)) ? '0 : r_br + 1'b1;
            if (r_br == '0) begin
              // Branch 0 has zero delay and never touches the RAM.
              r_do_data <= i_di;
              r_do_rdy  <= 1'b1;
              r_state   <= ST_OUT;
            end else begin
              r_hold     <= i_di;
              r_cur_br   <= r_br;
              r_ram_addr <= branch_base(r_br) + ADDR_W'(r_ptr[r_br]);
              r_ram_we   <= 1'b0;
              r_state    <= ST_RD;
            end
          end
        end
        ST_RD: begin
          // Same address: the read was sampled at this edge, so overwrite it now.
          r_ram_we    <= 1'b1;
          r_ram_wdata <= r_hold;
          r_state     <= ST_WR;
        end
        ST_WR: begin
          // i_ram_rdata still carries the pre-write contents read in RD.
          r_do_data <= i_ram_rdata;
          r_do_rdy  <= 1'b1;
          r_ram_we  <= 1'b0;
          r_ptr[r_cur_br] <= (r_ptr[r_cur_br] == ptr_last(r_cur_br)) ?
                             '0 : r_ptr[r_cur_br] + 1'b1;
          r_state   <= ST_OUT;
        end
        ST_OUT: begin
          if (i_do_acpt) begin
            r_do_rdy <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_do_rdy <= 1'b0;
          r_ram_we <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Packet/byte position tracking and sync error pulse; never resynchronises.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bc       <= 8'd0;
      r_pc       <= 3'd0;
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= w_sync_bad;
      if (w_xfer) begin
        if (r_bc == BC_LAST) begin
          r_bc <= 8'd0;
          r_pc <= r_pc + 3'd1;
        end else begin
          r_bc <= r_bc + 8'd1;
        end
      end
    end
  end

  assign o_do_rdy    = r_do_rdy;
  assign o_do_data   = r_do_data;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_we    = r_ram_we;
  assign o_ram_wdata = r_ram_wdata;
  assign o_sync_err  = r_sync_err;

endmodule

// File: tb/tb_interleaver_ram_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for interleaver_ram_ctrl. A RAM model is attached. The reference
// model keeps the history of every branch and derives each expected output
// from one rule: branch k returns the byte it received M*k transfers
// earlier. Before that history exists, it returns the RAM contents present
// at reset. Expected outputs, RAM writes and sync pulses are queued when a
// byte is accepted. A negedge monitor pops them and compares.
// -----------------------------------------------------------------------------
module tb_interleaver_ram_ctrl;
  localparam int WIDTH  = 8;
  localparam int M      = 17;
  localparam int B      = 12;
  localparam int ADDR_W = 11;
  localparam int PKT    = 204;

  logic              clk = 1'b0;
  logic              reset, enable, di_rdy, di_acpt, do_rdy, do_acpt, ram_we, sync_err;
  logic [WIDTH-1:0]  di, do_data, ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] ram_addr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } wr_t;

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];
  logic [WIDTH-1:0] exp_q [$];
  wr_t              wr_q [$];
  logic [WIDTH-1:0] hist   [B][512];
  logic [WIDTH-1:0] init_v [B][256];
  int               cnt [B];
  int               n_ep, last_t, exp_lat;
  logic             exp_sync_pend, need_rebuild, lat_armed, prev_rdy;
  logic             stall, en_force;
  int               n_sent;

  interleaver_ram_ctrl #(.WIDTH(WIDTH), .M(M), .B(B), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable),
    .i_di_rdy(di_rdy), .o_di_acpt(di_acpt), .i_di(di),
    .o_do_rdy(do_rdy), .i_do_acpt(do_acpt), .o_do_data(do_data),
    .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata), .o_sync_err(sync_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port synchronous RAM, read-before-write.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // After reset every pointer is 0, so branch k first replays its RAM region in order.
  task automatic rebuild();
    for (int k = 0; k < B; k++) begin
      cnt[k] = 0;
      for (int i = 0; i < M * k; i++) init_v[k][i] = mem[M * k * (k - 1) / 2 + i];
    end
  endtask

  // Monitor + scoreboard. It records transfers that happen at the next posedge.
  always @(negedge clk) begin
    int k, c, bc, pc;
    logic [WIDTH-1:0] e;
    wr_t w;
    chk("sync_err", int'(sync_err), int'(exp_sync_pend));
    if (reset) begin
      chk("rst_di_acpt", int'(di_acpt), 0);
      chk("rst_do_rdy", int'(do_rdy), 0);
      chk("rst_ram_we", int'(ram_we), 0);
      chk("rst_ram_addr", int'(ram_addr), 0);
      chk("rst_ram_wdata", int'(ram_wdata), 0);
      chk("rst_do_data", int'(do_data), 0);
      exp_q.delete();
      wr_q.delete();
      exp_sync_pend = 1'b0;
      n_ep = 0;
      need_rebuild = 1'b1;
      lat_armed = 1'b0;
    end else begin
      if (need_rebuild) begin
        rebuild();
        need_rebuild = 1'b0;
      end
      if (do_rdy && !prev_rdy && lat_armed) begin
        chk("latency", cyc - last_t, exp_lat);
        lat_armed = 1'b0;
      end
      if (do_rdy && do_acpt) begin
        if (exp_q.size() == 0) flag("do_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("do_data", int'(do_data), int'(e));
        end
      end
      if (ram_we) begin
        if (wr_q.size() == 0) flag("ram_we_unexpected");
        else begin
          w = wr_q.pop_front();
          chk("ram_addr", int'(ram_addr), int'(w.addr));
          chk("ram_wdata", int'(ram_wdata), int'(w.data));
        end
      end
      exp_sync_pend = 1'b0;
      if (di_rdy && di_acpt) begin
        k  = n_ep % B;
        c  = cnt[k];
        bc = n_ep % PKT;
        pc = (n_ep / PKT) % 8;
        exp_sync_pend = (bc == 0) && (di != ((pc == 0) ? 8'hB8 : 8'h47));
        if (k == 0) e = di;
        else if (c < M * k) e = init_v[k][c];
        else e = hist[k][c - M * k];
        hist[k][c] = di;
        cnt[k] = c + 1;
        exp_q.push_back(e);
        if (k > 0) begin
          w.addr = ADDR_W'(M * k * (k - 1) / 2 + c % (M * k));
          w.data = di;
          wr_q.push_back(w);
        end
        last_t    = cyc;
        exp_lat   = (k == 0) ? 1 : 3;
        lat_armed = 1'b1;
        n_ep++;
      end
    end
    prev_rdy = do_rdy;
  end

  // Downstream acceptor and enable driver, changed just after each posedge.
  initial begin
    do_acpt = 1'b0;
    enable  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      do_acpt = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      enable  = en_force ? 1'b1 : ($urandom_range(0, 4) != 0);
    end
  end

  function automatic logic [WIDTH-1:0] gen(input int n);
    int p;
    if (n % PKT == 0) begin
      p = n / PKT;
      case (p % 3)
        1: return 8'h47;
        2: return 8'hB8;
        default: return 8'($urandom);
      endcase
    end
    return 8'($urandom);
  endfunction

  // Called just after a posedge; returns just after the transfer edge.
  task automatic send_byte(input logic [WIDTH-1:0] b);
    int t;
    di = b;
    di_rdy = 1'b1;
    t = 0;
    @(negedge clk);
    while (!di_acpt && t < 80) begin
      t++;
      @(negedge clk);
    end
    if (!di_acpt) flag("send_timeout");
    @(posedge clk);
    #1;
    di_rdy = 1'b0;
  endtask

  task automatic stream(input int num);
    for (int i = 0; i < num; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      send_byte(gen(n_sent));
      n_sent++;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) flag("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    logic found;
    reset = 1'b1; di_rdy = 1'b0; di = '0; stall = 1'b0; en_force = 1'b1;
    exp_sync_pend = 1'b0; need_rebuild = 1'b1; lat_armed = 1'b0; prev_rdy = 1'b0;
    n_ep = 0; last_t = 0; exp_lat = 0; n_sent = 0;
    ram_rdata = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Sync byte on branch 0, then a branch-1 byte, then enough to recirculate it.
    send_byte(8'hB8); n_sent++;
    send_byte(8'h11); n_sent++;
    en_force = 1'b0;
    stream(12 * 17);

    // Downstream stall while a byte sits in OUT.
    drain();
    stall = 1'b1; en_force = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_byte(gen(n_sent)); n_sent++;
    t = 0;
    while (!do_rdy && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (!do_rdy) flag("stall_rdy_timeout");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_do_rdy", int'(do_rdy), 1);
      if (exp_q.size() != 0) chk("stall_do_data", int'(do_data), int'(exp_q[0]));
      chk("stall_di_acpt", int'(di_acpt), 0);
      chk("stall_ram_we", int'(ram_we), 0);
    end
    @(posedge clk);
    #1;
    stall = 1'b0; en_force = 1'b0;

    // Long run: every branch wraps its region; packet counter wraps to 0.
    stream(12 * 187 + 12);

    // Reset asserted while a branch-k byte is in WR.
    en_force = 1'b1;
    drain();
    if (n_sent % B == 0) begin
      send_byte(gen(n_sent)); n_sent++;
      drain();
    end
    di = 8'($urandom);
    di_rdy = 1'b1;
    found = 1'b0;
    t = 0;
    while (!found && t < 40) begin
      @(negedge clk);
      t++;
      if (ram_we) found = 1'b1;
    end
    if (!found) flag("wr_state_timeout");
    #1;
    reset = 1'b1;
    di_rdy = 1'b0;
    @(posedge clk);
    #1;
    chk("rwr_do_rdy", int'(do_rdy), 0);
    chk("rwr_ram_we", int'(ram_we), 0);
    chk("rwr_di_acpt", int'(di_acpt), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_sent = 0;
    @(negedge clk);
    chk("post_rst_di_acpt", int'(di_acpt), 1);
    @(posedge clk);
    #1;
    // Wrong sync for packet 0 (pulse expected), then more traffic.
    send_byte(8'h47); n_sent++;
    en_force = 1'b0;
    stream(40);
    drain();
    repeat (3) @(posedge clk);
    chk("wr_q_left", wr_q.size(), 0);
    chk("exp_q_left", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
